// File: rtl/spike_packet_decoder.sv
// Decodes the NI flit stream into axon-spike frames (SPIKE packets) and
// per-flit configuration write strobes (CONFIG packets).
module spike_packet_decoder #(
    parameter int unsigned FLIT_WIDTH    = 38,
    parameter int unsigned PAYLOAD_WIDTH = 32,
    parameter int unsigned NUM_AXONS     = 256,
    parameter int unsigned CHUNK_WIDTH   = 16
) (
    input  logic                  neuron_clk,
    input  logic                  neuron_rst,
    input  logic                  start,
    input  logic                  activate_decoder,
    input  logic                  stall_decoder,
    input  logic [FLIT_WIDTH-1:0] flit_to_decoder,
    input  logic [2:0]            packet_type,
    output logic [NUM_AXONS-1:0]  axon_spikes,
    output logic                  spike_frame_valid,
    output logic [9:0]            src_id,
    output logic                  cfg_wr_en,
    output logic [12:0]           cfg_addr,
    output logic [15:0]           cfg_data,
    output logic                  decode_busy,
    output logic                  decode_error
);

    localparam int unsigned NUM_CHUNKS = NUM_AXONS / CHUNK_WIDTH;
    localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_HEAD = 2'd1;
    localparam logic [1:0] DATA      = 2'd2;

    localparam logic [1:0] HDR_HEAD   = 2'b10;
    localparam logic [1:0] HDR_TAIL   = 2'b01;
    localparam logic [1:0] HDR_SINGLE = 2'b11;

    localparam logic [2:0] TYPE_SPIKE  = 3'b000;
    localparam logic [2:0] TYPE_CONFIG = 3'b001;

    logic [1:0]               state, state_next;
    logic [2:0]               type_reg, type_next;
    logic [9:0]               src_reg, src_next;
    logic [CNT_W-1:0]         chunk_cnt, cnt_next;
    logic [NUM_AXONS-1:0]     shadow, shadow_next;
    logic [NUM_AXONS-1:0]     frame_next;
    logic [9:0]               src_id_next;
    logic                     frame_valid_next;
    logic                     cfg_wr_next;
    logic [12:0]              cfg_addr_next;
    logic [15:0]              cfg_data_next;
    logic                     busy_next;
    logic                     error_next;
    logic                     consume;
    logic                     complete;

    logic [1:0]               header;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic                     unused_bits;

    assign header      = flit_to_decoder[FLIT_WIDTH-1 -: 2];
    assign payload     = flit_to_decoder[PAYLOAD_WIDTH-1:0];
    assign unused_bits = ^{flit_to_decoder[FLIT_WIDTH-3 -: 4], payload[PAYLOAD_WIDTH-1 -: 3]};

    // State register plus every datapath/output register.
    always_ff @(posedge neuron_clk or negedge neuron_rst) begin
        if (!neuron_rst) begin
            state             <= IDLE;
            type_reg          <= '0;
            src_reg           <= '0;
            chunk_cnt         <= '0;
            shadow            <= '0;
            axon_spikes       <= '0;
            spike_frame_valid <= 1'b0;
            src_id            <= '0;
            cfg_wr_en         <= 1'b0;
            cfg_addr          <= '0;
            cfg_data          <= '0;
            decode_busy       <= 1'b0;
            decode_error      <= 1'b0;
        end else begin
            state             <= state_next;
            type_reg          <= type_next;
            src_reg           <= src_next;
            chunk_cnt         <= cnt_next;
            shadow            <= shadow_next;
            axon_spikes       <= frame_next;
            spike_frame_valid <= frame_valid_next;
            src_id            <= src_id_next;
            cfg_wr_en         <= cfg_wr_next;
            cfg_addr          <= cfg_addr_next;
            cfg_data          <= cfg_data_next;
            decode_busy       <= busy_next;
            decode_error      <= error_next;
        end
    end

    // Next-state and next-output logic; activate wins over a flit in the same cycle.
    always_comb begin
        state_next       = state;
        type_next        = type_reg;
        src_next         = src_reg;
        cnt_next         = chunk_cnt;
        shadow_next      = shadow;
        frame_next       = axon_spikes;
        src_id_next      = src_id;
        frame_valid_next = 1'b0;
        cfg_wr_next      = 1'b0;
        cfg_addr_next    = cfg_addr;
        cfg_data_next    = cfg_data;
        error_next       = decode_error;
        complete         = 1'b0;
        consume          = (state != IDLE) && !stall_decoder;

        if (activate_decoder) begin
            if (state != IDLE) error_next = 1'b1;
            type_next   = packet_type;
            cnt_next    = '0;
            shadow_next = '0;
            state_next  = WAIT_HEAD;
        end else if (consume) begin
            if (state == WAIT_HEAD || header[1]) begin
                // Head or head+tail; a head seen in DATA replaces the current packet.
                if (state == DATA) error_next = 1'b1;
                if (header == HDR_HEAD || header == HDR_SINGLE) begin
                    src_next    = payload[9:0];
                    cnt_next    = '0;
                    shadow_next = '0;
                    if (header == HDR_SINGLE) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end else begin
                case (type_reg)
                    TYPE_SPIKE: begin
                        if (chunk_cnt < CNT_W'(NUM_CHUNKS)) begin
                            for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
                                if (chunk_cnt == CNT_W'(i))
                                    shadow_next[i*CHUNK_WIDTH +: CHUNK_WIDTH] = payload[CHUNK_WIDTH-1:0];
                            end
                            cnt_next = chunk_cnt + CNT_W'(1);
                        end else begin
                            error_next = 1'b1;
                        end
                    end
                    TYPE_CONFIG: begin
                        cfg_wr_next   = 1'b1;
                        cfg_addr_next = payload[28:16];
                        cfg_data_next = payload[15:0];
                    end
                    default: error_next = 1'b1;
                endcase
                if (header == HDR_TAIL) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
        end

        if (complete && type_reg == TYPE_SPIKE) begin
            frame_next       = shadow_next;
            src_id_next      = src_next;
            frame_valid_next = 1'b1;
        end

        busy_next = (state_next != IDLE);

        // Synchronous clear overrides everything else this cycle.
        if (start) begin
            state_next       = IDLE;
            type_next        = '0;
            src_next         = '0;
            cnt_next         = '0;
            shadow_next      = '0;
            frame_next       = '0;
            src_id_next      = '0;
            frame_valid_next = 1'b0;
            cfg_wr_next      = 1'b0;
            cfg_addr_next    = '0;
            cfg_data_next    = '0;
            busy_next        = 1'b0;
            error_next       = 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_packet_decoder.sv
// Self-checking bench for spike_packet_decoder: directed scenarios plus
// randomized packets compared against a packet-level reference model.
module tb_spike_packet_decoder;

    logic         neuron_clk = 1'b0;
    logic         neuron_rst;
    logic         start;
    logic         activate_decoder;
    logic         stall_decoder;
    logic [37:0]  flit_to_decoder;
    logic [2:0]   packet_type;
    logic [255:0] axon_spikes;
    logic         spike_frame_valid;
    logic [9:0]   src_id;
    logic         cfg_wr_en;
    logic [12:0]  cfg_addr;
    logic [15:0]  cfg_data;
    logic         decode_busy;
    logic         decode_error;

    spike_packet_decoder dut (
        .neuron_clk        (neuron_clk),
        .neuron_rst        (neuron_rst),
        .start             (start),
        .activate_decoder  (activate_decoder),
        .stall_decoder     (stall_decoder),
        .flit_to_decoder   (flit_to_decoder),
        .packet_type       (packet_type),
        .axon_spikes       (axon_spikes),
        .spike_frame_valid (spike_frame_valid),
        .src_id            (src_id),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .decode_busy       (decode_busy),
        .decode_error      (decode_error)
    );

    always #5 neuron_clk = ~neuron_clk;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           frame_cnt;
    int           frame_cyc;
    int           tail_cyc;
    logic [255:0] obs_frame;
    logic [9:0]   obs_src;
    logic [28:0]  obs_cfg[$];
    int           obs_cfg_cyc[$];
    logic [31:0]  pkt_data[$];

    // One clock cycle of stimulus, then record what the DUT published.
    task automatic step(input logic act, input logic [2:0] ptype, input logic stl,
                        input logic [1:0] hdr, input logic [31:0] pl);
        activate_decoder = act;
        packet_type      = act ? ptype : 3'($urandom);
        stall_decoder    = stl;
        flit_to_decoder  = {hdr, 4'($urandom), pl};
        @(posedge neuron_clk);
        #1;
        cyc++;
        if (spike_frame_valid) begin
            frame_cnt++;
            frame_cyc = cyc;
            obs_frame = axon_spikes;
            obs_src   = src_id;
        end
        if (cfg_wr_en) begin
            obs_cfg.push_back({cfg_addr, cfg_data});
            obs_cfg_cyc.push_back(cyc);
        end
        activate_decoder = 1'b0;
        stall_decoder    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'b000, 1'b0, 2'b00, $urandom);
    endtask

    task automatic clear_obs();
        frame_cnt = 0;
        frame_cyc = -1;
        obs_cfg.delete();
        obs_cfg_cyc.delete();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step(1'b0, 3'b000, 1'b0, 2'b00, $urandom);
        start = 1'b0;
    endtask

    // Activate, optional bubbles, head, then pkt_data as data flits.
    task automatic send_packet(input logic [2:0] ptype, input logic [9:0] src, input int bubbles,
                               input int stall_at, input int stall_len, input bit rnd_stall,
                               input bit with_tail);
        step(1'b1, ptype, 1'b0, 2'b10, $urandom);
        repeat (bubbles) step(1'b0, 3'b000, 1'b0, ($urandom % 2 == 0) ? 2'b00 : 2'b01, $urandom);
        step(1'b0, 3'b000, 1'b0, 2'b10, {22'($urandom), src});
        for (int i = 0; i < pkt_data.size(); i++) begin
            if (i == stall_at) repeat (stall_len) step(1'b0, 3'b000, 1'b1, 2'($urandom), $urandom);
            if (rnd_stall && $urandom_range(0, 3) == 0) step(1'b0, 3'b000, 1'b1, 2'($urandom), $urandom);
            if (with_tail && i == pkt_data.size() - 1) begin
                step(1'b0, 3'b000, 1'b0, 2'b01, pkt_data[i]);
                tail_cyc = cyc;
            end else begin
                step(1'b0, 3'b000, 1'b0, 2'b00, pkt_data[i]);
            end
        end
    endtask

    // Reference frame: first 16 chunks in order, everything else zero.
    function automatic logic [255:0] exp_frame();
        logic [255:0] f = '0;
        for (int k = 0; k < pkt_data.size() && k < 16; k++) f[k*16 +: 16] = pkt_data[k][15:0];
        return f;
    endfunction

    function automatic logic [272:0] all_outputs();
        return {axon_spikes, spike_frame_valid, src_id[5:0], cfg_wr_en, cfg_addr[5:0], decode_busy, decode_error};
    endfunction

    task automatic test_reset();
        neuron_rst = 1'b0; start = 1'b0; activate_decoder = 1'b0; stall_decoder = 1'b0;
        flit_to_decoder = '0; packet_type = '0;
        repeat (3) @(posedge neuron_clk);
        #1;
        checks++;
        if ({axon_spikes, spike_frame_valid, src_id, cfg_wr_en, cfg_addr, cfg_data, decode_busy, decode_error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b err=%b src=%h cfg=%b/%h/%h frame=%h, want all zero",
                     decode_busy, decode_error, src_id, cfg_wr_en, cfg_addr, cfg_data, axon_spikes);
        end
        neuron_rst = 1'b1;
        clear_obs();
    endtask

    task automatic test_spike_basic();
        logic [255:0] exp;
        clear_obs();
        pkt_data.delete();
        for (int i = 0; i < 16; i++) pkt_data.push_back({16'($urandom), 16'(i)});
        exp = exp_frame();
        send_packet(3'b000, 10'h2A5, 0, -1, 0, 1'b0, 1'b1);
        checks++;
        if (decode_busy !== 1'b0) begin failures++; $display("FAIL spike_busy_after_tail: got %b want 0", decode_busy); end
        idle(2);
        checks++;
        if (frame_cnt !== 1) begin failures++; $display("FAIL spike_pulse_count: got %0d want 1", frame_cnt); end
        checks++;
        if (frame_cyc !== tail_cyc) begin failures++; $display("FAIL spike_pulse_timing: got cycle %0d want %0d", frame_cyc, tail_cyc); end
        checks++;
        if (obs_frame !== exp) begin failures++; $display("FAIL spike_frame: got %h want %h", obs_frame, exp); end
        checks++;
        if (obs_src !== 10'h2A5) begin failures++; $display("FAIL spike_src: got %h want 2a5", obs_src); end
        checks++;
        if (axon_spikes !== exp) begin failures++; $display("FAIL spike_hold: got %h want %h", axon_spikes, exp); end
        checks++;
        if (decode_error !== 1'b0 || obs_cfg.size() !== 0) begin
            failures++; $display("FAIL spike_side_effects: got err=%b cfg_writes=%0d want 0/0", decode_error, obs_cfg.size());
        end
    endtask

    task automatic test_config();
        clear_obs();
        pkt_data.delete();
        pkt_data.push_back({3'b001, 13'h0123, 16'hBEEF});
        pkt_data.push_back({3'b001, 13'h1FFF, 16'h0001});
        send_packet(3'b001, 10'($urandom), 0, -1, 0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (obs_cfg.size() !== 2) begin
            failures++; $display("FAIL cfg_count: got %0d want 2", obs_cfg.size());
        end else begin
            checks++;
            if (obs_cfg[0] !== {13'h0123, 16'hBEEF} || obs_cfg[1] !== {13'h1FFF, 16'h0001}) begin
                failures++; $display("FAIL cfg_values: got %h,%h want %h,%h", obs_cfg[0], obs_cfg[1],
                                     {13'h0123, 16'hBEEF}, {13'h1FFF, 16'h0001});
            end
            checks++;
            if (obs_cfg_cyc[1] !== obs_cfg_cyc[0] + 1 || obs_cfg_cyc[1] !== tail_cyc) begin
                failures++; $display("FAIL cfg_back_to_back: got cycles %0d,%0d want %0d,%0d",
                                     obs_cfg_cyc[0], obs_cfg_cyc[1], tail_cyc - 1, tail_cyc);
            end
        end
        checks++;
        if (frame_cnt !== 0 || decode_error !== 1'b0) begin
            failures++; $display("FAIL cfg_side_effects: got frames=%0d err=%b want 0/0", frame_cnt, decode_error);
        end
    endtask

    task automatic test_stall_bubble();
        logic [255:0] exp;
        clear_obs();
        pkt_data.delete();
        for (int i = 0; i < 16; i++) pkt_data.push_back({16'($urandom), 16'(i)});
        exp = exp_frame();
        send_packet(3'b000, 10'h2A5, 2, 7, 3, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (frame_cnt !== 1 || obs_frame !== exp || obs_src !== 10'h2A5) begin
            failures++; $display("FAIL stall_frame: got n=%0d src=%h frame=%h want 1/2a5/%h", frame_cnt, obs_src, obs_frame, exp);
        end
        checks++;
        if (frame_cyc !== tail_cyc || decode_error !== 1'b0) begin
            failures++; $display("FAIL stall_timing: got cycle %0d err=%b want %0d/0", frame_cyc, decode_error, tail_cyc);
        end
    endtask

    task automatic test_overflow_short();
        logic [255:0] exp;
        clear_obs();
        pkt_data.delete();
        for (int i = 0; i < 20; i++) pkt_data.push_back($urandom);
        exp = exp_frame();
        send_packet(3'b000, 10'($urandom), 0, -1, 0, 1'b0, 1'b1);
        checks++;
        if (decode_error !== 1'b1) begin failures++; $display("FAIL overflow_error: got %b want 1", decode_error); end
        checks++;
        if (frame_cnt !== 1 || obs_frame !== exp) begin
            failures++; $display("FAIL overflow_frame: got n=%0d frame=%h want 1/%h", frame_cnt, obs_frame, exp);
        end
        start_pulse();
        checks++;
        if (decode_error !== 1'b0 || axon_spikes !== '0) begin
            failures++; $display("FAIL start_clears_error: got err=%b frame=%h want 0/0", decode_error, axon_spikes);
        end
        clear_obs();
        pkt_data.delete();
        pkt_data.push_back($urandom);
        pkt_data.push_back($urandom);
        exp = {224'h0, pkt_data[1][15:0], pkt_data[0][15:0]};
        send_packet(3'b000, 10'($urandom), 0, -1, 0, 1'b0, 1'b1);
        checks++;
        if (frame_cnt !== 1 || obs_frame !== exp || decode_error !== 1'b0) begin
            failures++; $display("FAIL short_frame: got n=%0d err=%b frame=%h want 1/0/%h", frame_cnt, decode_error, obs_frame, exp);
        end
    endtask

    task automatic test_abort();
        logic [255:0] ref_frame;
        logic [28:0]  exp_cfg[$];
        start_pulse();
        pkt_data.delete();
        for (int i = 0; i < 16; i++) pkt_data.push_back($urandom);
        ref_frame = exp_frame();
        send_packet(3'b000, 10'($urandom), 0, -1, 0, 1'b0, 1'b1);
        clear_obs();
        pkt_data.delete();
        for (int i = 0; i < 5; i++) pkt_data.push_back($urandom);
        send_packet(3'b000, 10'($urandom), 0, -1, 0, 1'b0, 1'b0);
        checks++;
        if (decode_busy !== 1'b1) begin failures++; $display("FAIL abort_busy_mid: got %b want 1", decode_busy); end
        pkt_data.delete();
        for (int i = 0; i < 3; i++) begin
            pkt_data.push_back({3'b001, 13'($urandom), 16'($urandom)});
            exp_cfg.push_back(pkt_data[i][28:0]);
        end
        send_packet(3'b001, 10'($urandom), 0, -1, 0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (decode_error !== 1'b1 || frame_cnt !== 0) begin
            failures++; $display("FAIL abort_error: got err=%b frames=%0d want 1/0", decode_error, frame_cnt);
        end
        checks++;
        if (axon_spikes !== ref_frame) begin failures++; $display("FAIL abort_frame_hold: got %h want %h", axon_spikes, ref_frame); end
        checks++;
        if (obs_cfg !== exp_cfg) begin
            failures++; $display("FAIL abort_cfg: got %0d writes want %0d (first got %h want %h)",
                                 obs_cfg.size(), exp_cfg.size(), obs_cfg.size() > 0 ? obs_cfg[0] : 29'h0, exp_cfg[0]);
        end
    endtask

    task automatic test_reset_start_mid();
        logic [255:0] exp;
        pkt_data.delete();
        for (int i = 0; i < 8; i++) pkt_data.push_back($urandom);
        send_packet(3'b000, 10'($urandom), 0, -1, 0, 1'b0, 1'b0);
        #2 neuron_rst = 1'b0;
        #1;
        checks++;
        if ({axon_spikes, spike_frame_valid, src_id, cfg_wr_en, cfg_addr, cfg_data, decode_busy, decode_error} !== '0) begin
            failures++; $display("FAIL async_reset_mid: got busy=%b err=%b frame=%h want all zero", decode_busy, decode_error, axon_spikes);
        end
        @(posedge neuron_clk);
        #1 neuron_rst = 1'b1;
        clear_obs();
        pkt_data.delete();
        for (int i = 0; i < 16; i++) pkt_data.push_back($urandom);
        exp = exp_frame();
        send_packet(3'b000, 10'h155, 1, 4, 2, 1'b0, 1'b1);
        checks++;
        if (frame_cnt !== 1 || obs_frame !== exp || obs_src !== 10'h155 || decode_error !== 1'b0) begin
            failures++; $display("FAIL after_reset_packet: got n=%0d src=%h err=%b frame=%h want 1/155/0/%h",
                                 frame_cnt, obs_src, decode_error, obs_frame, exp);
        end
        pkt_data.delete();
        for (int i = 0; i < 6; i++) pkt_data.push_back($urandom);
        send_packet(3'b000, 10'($urandom), 0, -1, 0, 1'b0, 1'b0);
        start = 1'b1;
        step(1'b1, 3'b001, 1'b0, 2'b10, $urandom);
        start = 1'b0;
        checks++;
        if ({axon_spikes, spike_frame_valid, src_id, cfg_wr_en, cfg_addr, cfg_data, decode_busy, decode_error} !== '0) begin
            failures++; $display("FAIL start_mid: got busy=%b err=%b frame=%h want all zero", decode_busy, decode_error, axon_spikes);
        end
        step(1'b0, 3'b000, 1'b0, 2'b01, $urandom);
        clear_obs();
        pkt_data.delete();
        for (int i = 0; i < 16; i++) pkt_data.push_back($urandom);
        exp = exp_frame();
        send_packet(3'b000, 10'h0F0, 0, -1, 0, 1'b1, 1'b1);
        checks++;
        if (frame_cnt !== 1 || obs_frame !== exp || obs_src !== 10'h0F0 || decode_error !== 1'b0) begin
            failures++; $display("FAIL after_start_packet: got n=%0d src=%h err=%b frame=%h want 1/0f0/0/%h",
                                 frame_cnt, obs_src, decode_error, obs_frame, exp);
        end
    endtask

    // Random SPIKE / CONFIG / unknown packets, random gaps (including none) and stalls.
    task automatic test_random();
        logic         exp_err = 1'b0;
        logic [255:0] exp;
        logic [28:0]  exp_cfg[$];
        logic [2:0]   ptype;
        logic [9:0]   src;
        int           kind, n;
        start_pulse();
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 5);
            ptype = (kind <= 2) ? 3'b000 : (kind <= 4) ? 3'b001 : 3'($urandom_range(2, 7));
            n = (ptype == 3'b000) ? $urandom_range(1, 19) : $urandom_range(1, 4);
            src = 10'($urandom);
            pkt_data.delete();
            exp_cfg.delete();
            for (int i = 0; i < n; i++) begin
                pkt_data.push_back($urandom);
                exp_cfg.push_back(pkt_data[i][28:0]);
            end
            if (ptype == 3'b000 && n > 16) exp_err = 1'b1;
            if (ptype != 3'b000 && ptype != 3'b001) exp_err = 1'b1;
            exp = exp_frame();
            idle($urandom_range(0, 2));
            clear_obs();
            send_packet(ptype, src, $urandom_range(0, 2), -1, 0, 1'b1, 1'b1);
            checks++;
            if (decode_error !== exp_err) begin
                failures++; $display("FAIL rand_error[%0d]: got %b want %b", p, decode_error, exp_err);
            end
            if (ptype == 3'b000) begin
                checks++;
                if (frame_cnt !== 1 || obs_frame !== exp || obs_src !== src || obs_cfg.size() !== 0) begin
                    failures++; $display("FAIL rand_spike[%0d]: got n=%0d src=%h frame=%h want 1/%h/%h",
                                         p, frame_cnt, obs_src, obs_frame, src, exp);
                end
            end else begin
                if (ptype != 3'b001) exp_cfg.delete();
                checks++;
                if (frame_cnt !== 0 || obs_cfg !== exp_cfg) begin
                    failures++; $display("FAIL rand_cfg[%0d]: got frames=%0d writes=%0d want 0/%0d",
                                         p, frame_cnt, obs_cfg.size(), exp_cfg.size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_spike_basic();
        test_config();
        test_stall_bubble();
        test_overflow_short();
        test_abort();
        test_reset_start_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_packet_decoder.md
# spike_packet_decoder

Consumes the flit stream that the network interface (NI) emits on the neuron clock domain and decodes each packet into neuron-side actions. SPIKE packets are assembled into a full axon-spike frame, and CONFIG packets become per-flit configuration write strobes. The block sits directly downstream of the NI, between the NI and the neuron array/configuration memory, and is entirely in the neuron_clk domain.

## Interface
- FLIT_WIDTH, 38, flit width; flit = {header[1:0], vc[3:0], payload[31:0]}
- PAYLOAD_WIDTH, 32, payload width
- NUM_AXONS, 256, axon-spike frame width; must be a multiple of CHUNK_WIDTH
- CHUNK_WIDTH, 16, spike bits carried per data flit (payload[15:0])
- neuron_clk  in  1  block clock
- neuron_rst  in  1  asynchronous, active-low reset
- start  in  1  synchronous clear; same effect as reset, one cycle
- activate_decoder  in  1  one-cycle pulse from NI: a new packet begins
- stall_decoder  in  1  high: flit_to_decoder is not valid this cycle
- flit_to_decoder  in  FLIT_WIDTH  registered flit from NI
- packet_type  in  3  payload[31:29] of the packet head, valid in the activate_decoder cycle
- axon_spikes  out  NUM_AXONS  last complete spike frame
- spike_frame_valid  out  1  one-cycle pulse: axon_spikes was just updated
- src_id  out  10  {src_x[4:0], src_y[4:0]} of the last completed spike frame
- cfg_wr_en  out  1  one-cycle configuration write strobe
- cfg_addr  out  13  configuration address (payload[28:16])
- cfg_data  out  16  configuration data (payload[15:0])
- decode_busy  out  1  high while state != IDLE
- decode_error  out  1  sticky error flag; cleared only by reset or start

## Operation
- Header codes:
  - 2'b10 head
  - 2'b00 body
  - 2'b01 tail
  - 2'b11 single-flit packet (head+tail)
- Packet types:
  - 3'b000 SPIKE
  - 3'b001 CONFIG
  - others UNKNOWN
- A flit is *consumed* in any cycle where state ∈ {WAIT_HEAD, DATA} and stall_decoder == 0.
- States: IDLE, WAIT_HEAD, DATA.
- IDLE:
  - On activate_decoder, latch packet_type into type_reg, clear chunk_cnt, clear the shadow frame, and go to WAIT_HEAD.
- WAIT_HEAD:
  - A consumed flit with header 00 or 01 is a pipeline bubble: ignore it and stay.
  - Header 10: latch payload[9:0] into src_reg, go to DATA.
  - Header 11: the packet is complete with zero data flits. SPIKE publishes an all-zero frame; CONFIG issues no write. Go to IDLE.
- DATA, each consumed flit:
  - SPIKE: shadow[chunk_cnt*CHUNK_WIDTH +: CHUNK_WIDTH] <= payload[15:0]; chunk_cnt++.
  - CONFIG: on the next cycle assert cfg_wr_en with cfg_addr = payload[28:16] and cfg_data = payload[15:0].
  - UNKNOWN: discard the flit and set decode_error.
  - Header 01 (tail): the flit is processed as data, then go to IDLE.
  - Header 10 or 11 (unexpected head): set decode_error, treat the flit as a new head in place of the current packet, and keep type_reg unchanged.
- SPIKE completion (tail, or 11 in WAIT_HEAD):
  - Next cycle: axon_spikes <= shadow including the tail chunk, src_id <= src_reg, spike_frame_valid = 1.
- Chunk overflow: when chunk_cnt == NUM_AXONS/CHUNK_WIDTH, further data flits are dropped and set decode_error. chunk_cnt saturates and never wraps.
- Short SPIKE packets: unwritten chunks are published as 0.
- activate_decoder while state != IDLE:
  - Abort the current packet with no frame and no further cfg writes.
  - Set decode_error, restart in WAIT_HEAD with the new packet_type, and clear the shadow and chunk_cnt.
- stall_decoder high: no state change and nothing consumed; stall has no effect in IDLE.

## Timing
- Reset and start values:
  - All outputs 0.
  - State IDLE; type_reg, src_reg, chunk_cnt and shadow all 0.
- Reset is asynchronous assert; start is synchronous and overrides every other input in the same cycle.
- cfg_wr_en, cfg_addr and cfg_data are registered: valid exactly one cycle after the flit is consumed.
- Back-to-back CONFIG data flits give back-to-back cfg_wr_en.
- spike_frame_valid rises one cycle after the completing flit is consumed and lasts one cycle.
- axon_spikes and src_id hold their value until the next completed SPIKE frame.
- decode_busy = (state != IDLE), registered with the state.
- Minimum packet spacing: activate_decoder may arrive in the cycle after the tail is consumed, and is accepted normally.

## Test plan
- SPIKE packet: activate with type 000; head payload[9:0] = 10'h2A5; 16 data flits with payload[15:0] = chunk index i, the last one a tail, with no stalls.
  - Expect axon_spikes[16i+15:16i] = i for all i, src_id = 10'h2A5, one spike_frame_valid pulse the cycle after the tail, decode_error = 0.
- CONFIG packet: head, then body payload {3'b001, 13'h0123, 16'hBEEF}, then tail payload {3'b001, 13'h1FFF, 16'h0001}.
  - Expect two consecutive cfg_wr_en pulses with (0x0123, 0xBEEF) then (0x1FFF, 0x0001), and no spike_frame_valid.
- Stalls and bubbles: SPIKE packet with stall_decoder high for 3 cycles mid-packet, and two header-00 flits before the head.
  - Expect a frame identical to the no-stall case.
- Overflow and short packets:
  - A 20-data-flit SPIKE packet sets decode_error and publishes only the first 16 chunks.
  - A 2-data-flit packet publishes chunks 0–1 and zeros elsewhere.
- Abort: second activate_decoder after 5 of 16 SPIKE chunks, followed by a complete CONFIG packet.
  - Expect decode_error = 1, no frame pulse, correct cfg writes, and axon_spikes unchanged.
- Reset and start: assert neuron_rst mid-packet, and separately pulse start mid-packet.
  - Expect all outputs 0 and the state in IDLE; the next clean packet decodes correctly.
